latch_q_monitor: RTL and testbench



---
 rtl/latch_q_monitor_if.sv | 40 ++++
 rtl/latch_q_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_latch_q_monitor.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_q_monitor_if.sv
// Signal bundle between the latch side (master) and latch_q_monitor (slave).
// CNT_W must match the CNT_W of the monitor instance it connects to.
interface latch_q_monitor_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             q_in;
    logic             qbar_in;
    logic             cnt_clr;
    logic             q_clean;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] edge_cnt;
    logic             qbar_err;

    // Latch / stimulus side: drives the raw latch levels and the clear.
    modport master (
        output q_in,
        output qbar_in,
        output cnt_clr,
        input  q_clean,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_cnt,
        input  qbar_err
    );

    // Monitor side.
    modport slave (
        input  q_in,
        input  qbar_in,
        input  cnt_clr,
        output q_clean,
        output rise_pulse,
        output fall_pulse,
        output edge_cnt,
        output qbar_err
    );

endinterface

// File: rtl/latch_q_monitor.sv
// latch_q_monitor: synchronizes the asynchronous latch Q into the clk domain,
// rejects pulses shorter than FILT_CYCLES synchronized samples, and emits a
// clean level, one-cycle rise/fall strobes and a wrapping transition count.
// Optional feature macro: LATCH_QBAR_CHECK_EN enables the Q/Qbar complement
// check driving qbar_err; without it qbar_err is tied to 0.
module latch_q_monitor #(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    latch_q_monitor_if.slave   bus
);

    // Wide enough to hold FILT_CYCLES itself (needed by the violation counter).
    localparam int unsigned ScW = $clog2(FILT_CYCLES + 1);
    localparam logic [ScW-1:0] ScOne  = ScW'(1);
    localparam logic [ScW-1:0] ScLast = ScW'(FILT_CYCLES - 1);

    typedef enum logic [1:0] {
        StStable0,
        StPend1,
        StStable1,
        StPend0
    } state_e;

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [ScW-1:0]   sc_q, sc_d;
    logic             q_clean_q, q_clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sc_last;

    // sc + 1 == FILT_CYCLES, written without widening the counter.
    assign sc_last = (sc_q == ScLast);

    // Two-flop synchronizer for Q; only s2_q is used downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.q_in;
            s2_q <= s1_q;
        end
    end

    // Filter FSM state and stability counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StStable0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
        end
    end

    // Filter next state: a new level must be seen FILT_CYCLES times in a row.
    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        unique case (state_q)
            StStable0: begin
                if (s2_q) begin
                    if (FILT_CYCLES == 1) begin
                        state_d = StStable1;
                        sc_d    = '0;
                    end else begin
                        state_d = StPend1;
                        sc_d    = ScOne;
                    end
                end else begin
                    sc_d = '0;
                end
            end
            StPend1: begin
                if (s2_q) begin
                    if (sc_last) begin
                        state_d = StStable1;
                        sc_d    = '0;
                    end else begin
                        sc_d = sc_q + ScOne;
                    end
                end else begin
                    state_d = StStable0;
                    sc_d    = '0;
                end
            end
            StStable1: begin
                if (!s2_q) begin
                    if (FILT_CYCLES == 1) begin
                        state_d = StStable0;
                        sc_d    = '0;
                    end else begin
                        state_d = StPend0;
                        sc_d    = ScOne;
                    end
                end else begin
                    sc_d = '0;
                end
            end
            StPend0: begin
                if (!s2_q) begin
                    if (sc_last) begin
                        state_d = StStable0;
                        sc_d    = '0;
                    end else begin
                        sc_d = sc_q + ScOne;
                    end
                end else begin
                    state_d = StStable1;
                    sc_d    = '0;
                end
            end
            default: begin
                state_d = StStable0;
                sc_d    = '0;
            end
        endcase
    end

    // Output next values, derived from the next state so the level and the
    // strobe register on the same edge as the accepting transition.
    always_comb begin
        q_clean_d = (state_d == StStable1) || (state_d == StPend0);
        rise_d    = q_clean_d & ~q_clean_q;
        fall_d    = ~q_clean_d & q_clean_q;
        cnt_d     = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (rise_d || fall_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs and transition counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_clean_q <= q_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.q_clean    = q_clean_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.edge_cnt   = cnt_q;

`ifdef LATCH_QBAR_CHECK_EN
    localparam logic [ScW-1:0] VcMax = ScW'(FILT_CYCLES);

    logic           b1_q, b2_q;
    logic [ScW-1:0] vc_q, vc_d;
    logic           err_q, err_d;

    // Qbar synchronizer resets to 1 so reset itself is not a violation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b1_q <= 1'b1;
            b2_q <= 1'b1;
        end else begin
            b1_q <= bus.qbar_in;
            b2_q <= b1_q;
        end
    end

    // Count consecutive Q==Qbar samples (saturating); sticky error on reaching
    // FILT_CYCLES, clear has priority over a set.
    always_comb begin
        vc_d = '0;
        if (s2_q == b2_q) begin
            vc_d = (vc_q == VcMax) ? vc_q : vc_q + ScOne;
        end
        err_d = bus.cnt_clr ? 1'b0 : (err_q | (vc_d == VcMax));
    end

    // Violation counter and sticky error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            vc_q  <= vc_d;
            err_q <= err_d;
        end
    end

    assign bus.qbar_err = err_q;
`else
    logic unused_qbar;
    assign unused_qbar  = bus.qbar_in;
    assign bus.qbar_err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_q_monitor.sv
// Self-checking bench for latch_q_monitor. Two instances share the stimulus:
// inst0 FILT_CYCLES=4/CNT_W=2, inst1 FILT_CYCLES=1/CNT_W=3. A behavioural
// model (delay line + run lengths) is checked against both every cycle.
module tb_latch_q_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic q_in;
    logic qbar_in;
    logic cnt_clr;

    always #5 clk = ~clk;

    latch_q_monitor_if #(.CNT_W(2)) if_a ();
    latch_q_monitor_if #(.CNT_W(3)) if_b ();

    assign if_a.q_in    = q_in;
    assign if_a.qbar_in = qbar_in;
    assign if_a.cnt_clr = cnt_clr;
    assign if_b.q_in    = q_in;
    assign if_b.qbar_in = qbar_in;
    assign if_b.cnt_clr = cnt_clr;

    latch_q_monitor #(.FILT_CYCLES(4), .CNT_W(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    latch_q_monitor #(.FILT_CYCLES(1), .CNT_W(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

`ifdef LATCH_QBAR_CHECK_EN
    localparam int ExpErr = 1;
`else
    localparam int ExpErr = 0;
`endif

    int filt [2] = '{4, 1};
    int cw   [2] = '{2, 3};

    // Model state.
    bit m_p1, m_p2, m_b1, m_b2;
    int m_run  [2];
    bit m_clean[2];
    bit m_rise [2];
    bit m_fall [2];
    int m_cnt  [2];
    int m_vrun [2];
    bit m_err  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic cmp(input string name, input int inst, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d",
                     name, inst, cyc, got, exp);
        end
    endtask

    // One rising edge of the reference behaviour, using inputs as they are
    // at the edge.
    task automatic model_step();
        bit f, fb;
        if (!rst_n) begin
            m_p1 = 1'b0; m_p2 = 1'b0; m_b1 = 1'b1; m_b2 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_clean[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
                m_cnt[i] = 0; m_vrun[i] = 0; m_err[i] = 1'b0;
            end
        end else begin
            f  = m_p2;
            fb = m_b2;
            for (int i = 0; i < 2; i++) begin
                // Run of consecutive samples disagreeing with the clean level.
                m_run[i]  = (f != m_clean[i]) ? m_run[i] + 1 : 0;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (m_run[i] == filt[i]) begin
                    m_clean[i] = f;
                    m_run[i]   = 0;
                    m_rise[i]  = f;
                    m_fall[i]  = !f;
                    m_cnt[i]   = (m_cnt[i] + 1) % (1 << cw[i]);
                end
                if (cnt_clr) m_cnt[i] = 0;
`ifdef LATCH_QBAR_CHECK_EN
                m_vrun[i] = (f == fb) ? m_vrun[i] + 1 : 0;
                m_err[i]  = cnt_clr ? 1'b0 : (m_err[i] | (m_vrun[i] >= filt[i]));
`else
                m_vrun[i] = (fb == fb) ? 0 : 0;
                m_err[i]  = 1'b0;
`endif
            end
            m_p2 = m_p1; m_p1 = q_in;
            m_b2 = m_b1; m_b1 = qbar_in;
        end
    endtask

    task automatic cmp_inst(input int i, input int qc, input int rp, input int fp,
                            input int ec, input int qe);
        cmp("q_clean",    i, qc, int'(m_clean[i]));
        cmp("rise_pulse", i, rp, int'(m_rise[i]));
        cmp("fall_pulse", i, fp, int'(m_fall[i]));
        cmp("edge_cnt",   i, ec, m_cnt[i]);
        cmp("qbar_err",   i, qe, int'(m_err[i]));
        cmp("pulse_excl", i, rp & fp, 0);
    endtask

    task automatic compare_all();
        cmp_inst(0, int'(if_a.q_clean), int'(if_a.rise_pulse), int'(if_a.fall_pulse),
                 int'(if_a.edge_cnt), int'(if_a.qbar_err));
        cmp_inst(1, int'(if_b.q_clean), int'(if_b.rise_pulse), int'(if_b.fall_pulse),
                 int'(if_b.edge_cnt), int'(if_b.qbar_err));
    endtask

    // Advance one clock: model at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        cyc++;
    endtask

    task automatic set_q(input bit v);
        q_in    = v;
        qbar_in = ~v;
    endtask

    task automatic hold(input bit v, input int n);
        set_q(v);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; cnt_clr = 1'b0;
        set_q(1'b0);
        repeat (3) tick();
        cmp("lit_rst_qclean", 0, int'(if_a.q_clean), 0);
        cmp("lit_rst_cnt",    0, int'(if_a.edge_cnt), 0);
        cmp("lit_rst_cnt",    1, int'(if_b.edge_cnt), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Accepted rise: edge 6 for FILT=4, edge 3 for FILT=1.
        set_q(1'b1);
        repeat (2) tick();
        tick();
        cmp("lit_rise_f1_q",  1, int'(if_b.q_clean), 1);
        cmp("lit_rise_f1_p",  1, int'(if_b.rise_pulse), 1);
        cmp("lit_rise_e3_q",  0, int'(if_a.q_clean), 0);
        repeat (2) tick();
        cmp("lit_rise_e5_q",  0, int'(if_a.q_clean), 0);
        tick();
        cmp("lit_rise_e6_q",  0, int'(if_a.q_clean), 1);
        cmp("lit_rise_e6_p",  0, int'(if_a.rise_pulse), 1);
        cmp("lit_rise_e6_c",  0, int'(if_a.edge_cnt), 1);
        tick();
        cmp("lit_rise_e7_p",  0, int'(if_a.rise_pulse), 0);
        repeat (3) tick();

        hold(1'b0, 10);
        cmp("lit_fall_cnt",   0, int'(if_a.edge_cnt), 2);

        // Rejected 2-cycle glitch for FILT=4.
        hold(1'b1, 2);
        hold(1'b0, 8);
        cmp("lit_glitch_q",   0, int'(if_a.q_clean), 0);
        cmp("lit_glitch_cnt", 0, int'(if_a.edge_cnt), 2);

        // Wrap of the 2-bit counter.
        hold(1'b1, 8);
        cmp("lit_wrap_3",     0, int'(if_a.edge_cnt), 3);
        hold(1'b0, 8);
        cmp("lit_wrap_0",     0, int'(if_a.edge_cnt), 0);
        hold(1'b1, 8);
        cmp("lit_wrap_1",     0, int'(if_a.edge_cnt), 1);

        // Clear on the same edge as the accepted fall.
        hold(1'b0, 5);
        cnt_clr = 1'b1;
        tick();
        cmp("lit_clr_fall",   0, int'(if_a.fall_pulse), 1);
        cmp("lit_clr_cnt",    0, int'(if_a.edge_cnt), 0);
        cnt_clr = 1'b0;
        repeat (4) tick();

        // Reset while pending a rise, q_in held high through release.
        hold(1'b1, 4);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        cmp("lit_mid_e5_p",   0, int'(if_a.rise_pulse), 0);
        tick();
        cmp("lit_mid_e6_p",   0, int'(if_a.rise_pulse), 1);
        cmp("lit_mid_e6_c",   0, int'(if_a.edge_cnt), 1);
        repeat (6) tick();

        // Complement violation.
        qbar_in = 1'b1;
        repeat (8) tick();
        cmp("lit_qbar_set",   0, int'(if_a.qbar_err), ExpErr);
        qbar_in = 1'b0;
        repeat (4) tick();
        cmp("lit_qbar_hold",  0, int'(if_a.qbar_err), ExpErr);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
        cmp("lit_qbar_clr",   0, int'(if_a.qbar_err), 0);

        // Randomized runs of levels with occasional violations, clears, resets.
        for (int r = 0; r < 600; r++) begin
            bit v;
            bit viol;
            int len;
            v    = 1'($urandom_range(0, 1));
            viol = ($urandom_range(0, 9) == 0);
            len  = int'($urandom_range(1, 7));
            q_in    = v;
            qbar_in = viol ? v : ~v;
            for (int k = 0; k < len; k++) begin
                cnt_clr = ($urandom_range(0, 40) == 0);
                rst_n   = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        rst_n = 1'b1; cnt_clr = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
